// File: rtl/multiport_circular_buffer.sv
// Multi-port circular buffer: up to WR_PORTS pushes and RD_PORTS pops per cycle,
// first-word-fall-through head outputs, occupancy/status flags and error pulses.
module multiport_circular_buffer #(
  parameter type T         = logic [31:0],
  parameter int  DEPTH     = 8,
  parameter int  WR_PORTS  = 2,
  parameter int  RD_PORTS  = 2,
  parameter int  AF_THRESH = DEPTH - 2,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int WCW       = $clog2(WR_PORTS + 1),
  localparam int RCW       = $clog2(RD_PORTS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [WCW-1:0]      wr_cnt,
  input  T                    wr_data [WR_PORTS],
  input  logic [RCW-1:0]      rd_cnt,
  output T                    rd_data [RD_PORTS],
  output logic [RD_PORTS-1:0] rd_valid,
  output logic [CW-1:0]       count,
  output logic [CW-1:0]       free_cnt,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                overflow,
  output logic                underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry one wrap bit above the index bits.
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  T              mem [DEPTH];

  logic push_ok;
  logic pop_ok;

  // Index arithmetic on AW bits wraps modulo DEPTH for free.
  function automatic logic [AW-1:0] slot(input logic [AW-1:0] base, input int off);
    return base + AW'(off);
  endfunction

  // Both judged against pre-edge state; a same-cycle pop never makes room for a push.
  assign push_ok = (CW'(wr_cnt) <= free_cnt);
  assign pop_ok  = (CW'(rd_cnt) <= count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) tail <= tail + PW'(wr_cnt);
      if (pop_ok)  head <= head + PW'(rd_cnt);
      count     <= count + (push_ok ? CW'(wr_cnt) : '0) - (pop_ok ? CW'(rd_cnt) : '0);
      overflow  <= !push_ok;
      underflow <= !pop_ok;
    end
  end

  // NOTE: storage has no reset; validity is tracked solely by head/tail/count.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      for (int i = 0; i < WR_PORTS; i++) begin
        if (WCW'(i) < wr_cnt) mem[slot(tail[AW-1:0], i)] <= wr_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < RD_PORTS; i++) begin
      rd_data[i]  = mem[slot(head[AW-1:0], i)];
      rd_valid[i] = (count > CW'(i));
    end
  end

  assign free_cnt    = CW'(DEPTH) - count;
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_THRESH));

endmodule

// File: tb/tb_multiport_circular_buffer.sv
// Self-checking bench: directed vector table, async-reset probe and randomized
// traffic, all compared against a queue-based reference model.
module tb_multiport_circular_buffer;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  wr_cnt;
  logic [31:0] wr_data [2];
  logic [1:0]  rd_cnt;
  logic [31:0] rd_data [2];
  logic [1:0]  rd_valid;
  logic [3:0]  count;
  logic [3:0]  free_cnt;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        overflow;
  logic        underflow;

  multiport_circular_buffer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_cnt     (wr_cnt),
    .wr_data    (wr_data),
    .rd_cnt     (rd_cnt),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .free_cnt   (free_cnt),
    .full       (full),
    .empty      (empty),
    .almost_full(almost_full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: an ordered queue of live entries plus expected error pulses.
  logic [31:0] q [$];
  logic        m_ovf;
  logic        m_unf;

  typedef struct {
    logic [1:0]  wc;
    logic [1:0]  rc;
    logic        fl;
    logic [31:0] d0;
    logic [31:0] d1;
    int          ec;
    logic        eo;
    logic        eu;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [1:0] wc, input logic [1:0] rc, input logic fl,
                              input logic [31:0] d0, input logic [31:0] d1, input int ec,
                              input logic eo, input logic eu,
                              input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.wc = wc; v.rc = rc; v.fl = fl; v.d0 = d0; v.d1 = d1;
    v.ec = ec; v.eo = eo; v.eu = eu; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    int n;
    n = q.size();
    check({tag, " count"}, 32'(count), 32'(n));
    check({tag, " free_cnt"}, 32'(free_cnt), 32'(DEPTH - n));
    check({tag, " empty"}, 32'(empty), 32'(n == 0));
    check({tag, " full"}, 32'(full), 32'(n == DEPTH));
    check({tag, " almost_full"}, 32'(almost_full), 32'(n >= DEPTH - 2));
    check({tag, " rd_valid"}, 32'(rd_valid), {30'd0, n > 1, n > 0});
    if (n > 0) check({tag, " rd_data0"}, rd_data[0], q[0]);
    if (n > 1) check({tag, " rd_data1"}, rd_data[1], q[1]);
    check({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, " underflow"}, 32'(underflow), 32'(m_unf));
  endtask

  // Apply one cycle of stimulus and advance the model by the same rules.
  task automatic cycle(input logic [1:0] wc, input logic [1:0] rc, input logic fl,
                       input logic [31:0] d0, input logic [31:0] d1);
    int  n;
    bit  p_ok;
    bit  r_ok;
    n = q.size();
    wr_cnt = wc; rd_cnt = rc; flush = fl;
    wr_data[0] = d0; wr_data[1] = d1;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      p_ok = (int'(wc) <= DEPTH - n);
      r_ok = (int'(rc) <= n);
      if (r_ok) repeat (int'(rc)) void'(q.pop_front());
      if (p_ok) begin
        if (wc > 0) q.push_back(d0);
        if (wc > 1) q.push_back(d1);
      end
      m_ovf = !p_ok;
      m_unf = !r_ok;
    end
    @(posedge clk);
    #1;
    wr_cnt = '0; rd_cnt = '0; flush = 1'b0;
  endtask

  logic [1:0] r_wc;
  logic [1:0] r_rc;
  logic       r_fl;

  initial begin
    rst_n = 1'b0; flush = 1'b0; wr_cnt = '0; rd_cnt = '0;
    wr_data[0] = '0; wr_data[1] = '0;
    m_ovf = 1'b0; m_unf = 1'b0;

    // Fill, overflow, drain, underflow, wrap, simultaneous events, flush.
    tbl.push_back(mk(2, 0, 0,  0,  1, 2, 0, 0,  0,  1));
    tbl.push_back(mk(2, 0, 0,  2,  3, 4, 0, 0,  0,  1));
    tbl.push_back(mk(2, 0, 0,  4,  5, 6, 0, 0,  0,  1));
    tbl.push_back(mk(2, 0, 0,  6,  7, 8, 0, 0,  0,  1));
    tbl.push_back(mk(1, 0, 0, 99,  0, 8, 1, 0,  0,  1));
    tbl.push_back(mk(0, 2, 0,  0,  0, 6, 0, 0,  2,  3));
    tbl.push_back(mk(0, 2, 0,  0,  0, 4, 0, 0,  4,  5));
    tbl.push_back(mk(0, 2, 0,  0,  0, 2, 0, 0,  6,  7));
    tbl.push_back(mk(0, 2, 0,  0,  0, 0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 1, 0,  0,  0, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 1, 0,  0,  0, 0, 0, 1,  0,  0));
    tbl.push_back(mk(0, 0, 0,  0,  0, 0, 0, 0,  0,  0));
    tbl.push_back(mk(2, 0, 0, 10, 11, 2, 0, 0, 10, 11));
    tbl.push_back(mk(2, 0, 0, 12, 13, 4, 0, 0, 10, 11));
    tbl.push_back(mk(2, 0, 0, 14, 15, 6, 0, 0, 10, 11));
    tbl.push_back(mk(1, 0, 0, 16,  0, 7, 0, 0, 10, 11));
    tbl.push_back(mk(0, 2, 0,  0,  0, 5, 0, 0, 12, 13));
    tbl.push_back(mk(0, 2, 0,  0,  0, 3, 0, 0, 14, 15));
    tbl.push_back(mk(0, 2, 0,  0,  0, 1, 0, 0, 16,  0));
    tbl.push_back(mk(2, 0, 0, 17, 18, 3, 0, 0, 16, 17));
    tbl.push_back(mk(0, 2, 0,  0,  0, 1, 0, 0, 18,  0));
    tbl.push_back(mk(0, 1, 0,  0,  0, 0, 0, 0,  0,  0));
    tbl.push_back(mk(2, 0, 0, 20, 21, 2, 0, 0, 20, 21));
    tbl.push_back(mk(2, 0, 0, 22, 23, 4, 0, 0, 20, 21));
    tbl.push_back(mk(2, 0, 0, 24, 25, 6, 0, 0, 20, 21));
    tbl.push_back(mk(1, 0, 0, 26,  0, 7, 0, 0, 20, 21));
    tbl.push_back(mk(2, 2, 0, 27, 28, 5, 1, 0, 22, 23));
    tbl.push_back(mk(0, 2, 0,  0,  0, 3, 0, 0, 24, 25));
    tbl.push_back(mk(2, 1, 0, 30, 31, 4, 0, 0, 25, 26));
    tbl.push_back(mk(1, 0, 0, 32,  0, 5, 0, 0, 25, 26));
    tbl.push_back(mk(2, 1, 1, 40, 41, 0, 0, 0,  0,  0));
    tbl.push_back(mk(0, 2, 1,  0,  0, 0, 0, 0,  0,  0));
    tbl.push_back(mk(2, 0, 0, 50, 51, 2, 0, 0, 50, 51));

    // Reset state while rst_n is held low.
    #12;
    check("reset count", 32'(count), 32'd0);
    check("reset free_cnt", 32'(free_cnt), 32'd8);
    check("reset empty", 32'(empty), 32'd1);
    check("reset full", 32'(full), 32'd0);
    check("reset almost_full", 32'(almost_full), 32'd0);
    check("reset rd_valid", 32'(rd_valid), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    check("reset underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cycle(0, 0, 0, 0, 0);
    compare_model("idle");

    foreach (tbl[k]) begin
      cycle(tbl[k].wc, tbl[k].rc, tbl[k].fl, tbl[k].d0, tbl[k].d1);
      check($sformatf("vec%0d count", k), 32'(count), 32'(tbl[k].ec));
      check($sformatf("vec%0d overflow", k), 32'(overflow), 32'(tbl[k].eo));
      check($sformatf("vec%0d underflow", k), 32'(underflow), 32'(tbl[k].eu));
      if (tbl[k].ec > 0) check($sformatf("vec%0d rd_data0", k), rd_data[0], tbl[k].e0);
      if (tbl[k].ec > 1) check($sformatf("vec%0d rd_data1", k), rd_data[1], tbl[k].e1);
      compare_model($sformatf("vec%0d", k));
    end

    // Asynchronous reset in the middle of a drain takes effect without a clock edge.
    cycle(2, 0, 0, 32'h100, 32'h101);
    cycle(2, 0, 0, 32'h102, 32'h103);
    cycle(0, 1, 0, 0, 0);
    compare_model("pre-reset");
    #3;
    rst_n = 1'b0;
    #1;
    check("async count", 32'(count), 32'd0);
    check("async free_cnt", 32'(free_cnt), 32'd8);
    check("async empty", 32'(empty), 32'd1);
    check("async rd_valid", 32'(rd_valid), 32'd0);
    check("async overflow", 32'(overflow), 32'd0);
    check("async underflow", 32'(underflow), 32'd0);
    q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic: push-biased half then pop-biased half, rare flushes.
    for (int k = 0; k < 400; k++) begin
      r_wc = (k < 200) ? 2'($urandom_range(0, 2)) : 2'($urandom_range(0, 1));
      r_rc = (k < 200) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 2));
      r_fl = ($urandom_range(0, 24) == 0);
      cycle(r_wc, r_rc, r_fl, $urandom, $urandom);
      compare_model($sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
